store_write_buffer: RTL and testbench

//  Store-side counterpart of the MEM-stage load extraction path. Formats SB/SH/SW into

---
 rtl/store_write_buffer_if.sv | 28 ++
 rtl/store_write_buffer.sv | 108 ++++++++++
 tb/tb_store_write_buffer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if: store request, load probe and SRAM write bundle for store_write_buffer.
interface store_write_buffer_if #(parameter int PTR_W = 2);
   logic st_valid;
   logic st_ready;
   logic [2:0] st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic st_misalign;
   logic ld_req;
   logic [31:0] ld_addr;
   logic ld_hazard;
   logic data_sram_en;
   logic [3:0] data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [PTR_W:0] wb_count;
   logic wb_empty;
   modport master (
      output st_valid, st_op, st_addr, st_data, ld_req, ld_addr,
      input st_ready, st_misalign, ld_hazard, data_sram_en, data_sram_wen, data_sram_addr,
      data_sram_wdata, wb_count, wb_empty
   );
   modport slave (
      input st_valid, st_op, st_addr, st_data, ld_req, ld_addr,
      output st_ready, st_misalign, ld_hazard, data_sram_en, data_sram_wen, data_sram_addr,
      data_sram_wdata, wb_count, wb_empty
   );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer: formats SB/SH/SW, queues them in order and drains to the data SRAM when no load owns it.
// WBUF_COALESCE_EN: an aligned store hitting the tail entry's word merges into it instead of taking a slot.
module store_write_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic clk,
   input logic resetn,
   store_write_buffer_if.slave bus
);
   logic [29:0] addr_q [DEPTH];
   logic [29:0] addr_d [DEPTH];
   logic [3:0] wen_q [DEPTH];
   logic [3:0] wen_d [DEPTH];
   logic [31:0] wdata_q [DEPTH];
   logic [31:0] wdata_d [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0] count_q, count_d;
   logic misalign_q, misalign_d;
   logic is_sb, is_sh, is_sw, req, mis, full, empty, hit, drain, merge, enq;
   logic [1:0] o;
   logic [3:0] fwen;
   logic [31:0] fdata;
   always_comb begin
      is_sb = bus.st_op == 3'b100;
      is_sh = bus.st_op == 3'b010;
      is_sw = bus.st_op == 3'b001;
      o = bus.st_addr[1:0];
      req = bus.st_valid & (is_sb | is_sh | is_sw);
      mis = (is_sh & o[0]) | (is_sw & (o != 2'b00));
      fwen = is_sb ? 4'b0001 << o : is_sh ? (o[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      fdata = is_sb ? {4{bus.st_data[7:0]}} : is_sh ? {2{bus.st_data[15:0]}} : bus.st_data;
      full = count_q == (PTR_W+1)'(DEPTH);
      empty = count_q == '0;
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) hit = hit | (valid_q[i] & (addr_q[i] == bus.ld_addr[31:2]));
      bus.ld_hazard = bus.ld_req & (hit | (bus.st_valid & (bus.st_addr[31:2] == bus.ld_addr[31:2])));
      // a hazarded load gives up the port so the conflicting entry can drain
      drain = ~empty & ~(bus.ld_req & ~bus.ld_hazard);
`ifdef WBUF_COALESCE_EN
      merge = req & ~mis & ~empty & (addr_q[tail_q - 1'b1] == bus.st_addr[31:2])
            & ~(drain & (count_q == (PTR_W+1)'(1)));
`else
      merge = 1'b0;
`endif
      bus.st_ready = ~full | merge;
      enq = req & ~mis & ~full & ~merge;
   end
   always_comb begin
      addr_d = addr_q;
      wen_d = wen_q;
      wdata_d = wdata_q;
      valid_d = valid_q;
      head_d = head_q;
      tail_d = tail_q;
      misalign_d = req & mis;
      if (drain) begin
         valid_d[head_q] = 1'b0;
         head_d = head_q + 1'b1;
      end
      if (enq) begin
         valid_d[tail_q] = 1'b1;
         addr_d[tail_q] = bus.st_addr[31:2];
         wen_d[tail_q] = fwen;
         wdata_d[tail_q] = fdata;
         tail_d = tail_q + 1'b1;
      end
      if (merge) begin
         wen_d[tail_q - 1'b1] = wen_q[tail_q - 1'b1] | fwen;
         for (int b = 0; b < 4; b++)
            if (fwen[b]) wdata_d[tail_q - 1'b1][8*b +: 8] = fdata[8*b +: 8];
      end
      count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
   end
   always_comb begin
      bus.data_sram_en = drain;
      bus.data_sram_wen = drain ? wen_q[head_q] : 4'b0000;
      bus.data_sram_addr = drain ? {addr_q[head_q], 2'b00} : 32'b0;
      bus.data_sram_wdata = drain ? wdata_q[head_q] : 32'b0;
      bus.wb_count = count_q;
      bus.wb_empty = empty;
      bus.st_misalign = misalign_q;
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            wen_q[i] <= '0;
            wdata_q[i] <= '0;
         end
         valid_q <= '0;
         head_q <= '0;
         tail_q <= '0;
         count_q <= '0;
         misalign_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wen_q <= wen_d;
         wdata_q <= wdata_d;
         valid_q <= valid_d;
         head_q <= head_d;
         tail_q <= tail_d;
         count_q <= count_d;
         misalign_q <= misalign_d;
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_store_write_buffer;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int tests = 0;
   int fails = 0;
   typedef struct packed { logic [29:0] w; logic [3:0] wen; logic [31:0] data; } ent_t;
   ent_t q[$];
   always #5 clk = ~clk;
   store_write_buffer_if #(.PTR_W(2)) bus ();
   store_write_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.st_valid = 1'b0;
      bus.st_op = 3'b000;
      bus.st_addr = '0;
      bus.st_data = '0;
      bus.ld_req = 1'b0;
      bus.ld_addr = 32'h0000_9000;
   endtask
   task automatic st(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      bus.st_valid = 1'b1;
      bus.st_op = op;
      bus.st_addr = a;
      bus.st_data = d;
   endtask
   // kind: 0 = not a request, 1 = aligned store, 2 = misaligned store
   function automatic void fmt(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                               output int kind, output logic [3:0] wen, output logic [31:0] wd);
      kind = 0; wen = 4'h0; wd = 32'h0;
      case (op)
         3'b100: begin kind = 1; wen = 4'b0001 << a[1:0]; wd = {4{d[7:0]}}; end
         3'b010: begin kind = a[0] ? 2 : 1; wen = a[1] ? 4'hC : 4'h3; wd = {2{d[15:0]}}; end
         3'b001: begin kind = (a[1:0] == 2'b00) ? 1 : 2; wen = 4'hF; wd = d; end
         default: kind = 0;
      endcase
   endfunction
   task automatic test_reset();
      idle();
      resetn = 1'b0;
      #2;
      tests++; if (bus.wb_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.wb_count); end
      tests++; if (bus.wb_empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", bus.wb_empty); end
      tests++; if (bus.st_misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign: got %b want 0", bus.st_misalign); end
      tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL rst_en: got %b want 0", bus.data_sram_en); end
      @(negedge clk);
      resetn = 1'b1;
      tick();
   endtask
   task automatic test_sb();
      idle(); tick();
      st(3'b100, 32'h103, 32'hA5);
      #2;
      tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL sb_en_early: got %b want 0", bus.data_sram_en); end
      tick();
      bus.st_valid = 1'b0;
      #2;
      tests++; if (bus.data_sram_en !== 1'b1) begin fails++; $display("FAIL sb_en: got %b want 1", bus.data_sram_en); end
      tests++; if (bus.data_sram_wen !== 4'b1000) begin fails++; $display("FAIL sb_wen: got %b want 1000", bus.data_sram_wen); end
      tests++; if (bus.data_sram_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata: got %h want a5a5a5a5", bus.data_sram_wdata); end
      tests++; if (bus.data_sram_addr !== 32'h100) begin fails++; $display("FAIL sb_addr: got %h want 00000100", bus.data_sram_addr); end
      tick(); #2;
      tests++; if (bus.wb_empty !== 1'b1) begin fails++; $display("FAIL sb_empty: got %b want 1", bus.wb_empty); end
   endtask
   task automatic test_misalign();
      idle(); tick();
      st(3'b010, 32'h201, 32'h1234);
      tick();
      bus.st_valid = 1'b0;
      #2;
      tests++; if (bus.st_misalign !== 1'b1) begin fails++; $display("FAIL mis_pulse: got %b want 1", bus.st_misalign); end
      tests++; if (bus.wb_count !== 3'd0) begin fails++; $display("FAIL mis_count: got %0d want 0", bus.wb_count); end
      tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL mis_en: got %b want 0", bus.data_sram_en); end
      tick();
      tests++; if (bus.st_misalign !== 1'b0) begin fails++; $display("FAIL mis_fall: got %b want 0", bus.st_misalign); end
   endtask
   task automatic test_full_drain();
      logic [31:0] d [4];
      idle(); tick();
      bus.ld_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         st(3'b001, 32'h500 + 32'(4 * i), d[i]);
         tick();
      end
      bus.st_valid = 1'b0;
      #2;
      tests++; if (bus.wb_count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d want 4", bus.wb_count); end
      tests++; if (bus.st_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", bus.st_ready); end
      tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL full_en: got %b want 0", bus.data_sram_en); end
      bus.ld_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         tests++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_addr !== 32'h500 + 32'(4 * i) || bus.data_sram_wdata !== d[i]) begin
            fails++; $display("FAIL drain_%0d: got en %b addr %h data %h want 1 %h %h", i, bus.data_sram_en, bus.data_sram_addr, bus.data_sram_wdata, 32'h500 + 32'(4 * i), d[i]);
         end
         tick();
      end
      #2;
      tests++; if (bus.wb_empty !== 1'b1 || bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL drain_done: got empty %b en %b want 1 0", bus.wb_empty, bus.data_sram_en); end
   endtask
   task automatic test_hazard();
      idle(); tick();
      st(3'b001, 32'h300, 32'hCAFE_F00D);
      tick();
      bus.st_valid = 1'b0;
      bus.ld_req = 1'b1;
      bus.ld_addr = 32'h302;
      #2;
      tests++; if (bus.ld_hazard !== 1'b1) begin fails++; $display("FAIL haz_on: got %b want 1", bus.ld_hazard); end
      tests++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_addr !== 32'h300) begin fails++; $display("FAIL haz_drain: got en %b addr %h want 1 00000300", bus.data_sram_en, bus.data_sram_addr); end
      tick(); #2;
      tests++; if (bus.ld_hazard !== 1'b0) begin fails++; $display("FAIL haz_off: got %b want 0", bus.ld_hazard); end
      tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL haz_en_off: got %b want 0", bus.data_sram_en); end
   endtask
   task automatic test_full_enq();
      logic [31:0] exp_a [4];
      idle(); tick();
      bus.ld_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         st(3'b001, 32'h600 + 32'(4 * i), $urandom);
         tick();
      end
      bus.ld_req = 1'b0;
      st(3'b001, 32'h700, 32'h7777_7777);
      #2;
      tests++; if (bus.st_ready !== 1'b0) begin fails++; $display("FAIL fe_ready0: got %b want 0", bus.st_ready); end
      tests++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_addr !== 32'h600) begin fails++; $display("FAIL fe_drain: got en %b addr %h want 1 00000600", bus.data_sram_en, bus.data_sram_addr); end
      tick();
      bus.ld_req = 1'b1;
      #2;
      tests++; if (bus.wb_count !== 3'd3) begin fails++; $display("FAIL fe_count3: got %0d want 3", bus.wb_count); end
      tests++; if (bus.st_ready !== 1'b1) begin fails++; $display("FAIL fe_ready1: got %b want 1", bus.st_ready); end
      tick();
      bus.st_valid = 1'b0;
      #2;
      tests++; if (bus.wb_count !== 3'd4) begin fails++; $display("FAIL fe_count4: got %0d want 4", bus.wb_count); end
      exp_a = '{32'h604, 32'h608, 32'h60C, 32'h700};
      bus.ld_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #2;
         tests++; if (bus.data_sram_en !== 1'b1 || bus.data_sram_addr !== exp_a[i]) begin fails++; $display("FAIL fe_order_%0d: got en %b addr %h want 1 %h", i, bus.data_sram_en, bus.data_sram_addr, exp_a[i]); end
         tick();
      end
   endtask
   task automatic test_coalesce();
      idle(); tick();
      bus.ld_req = 1'b1;
      st(3'b100, 32'h400, 32'h11);
      tick();
      st(3'b100, 32'h401, 32'h22);
      tick();
      bus.st_valid = 1'b0;
      #2;
`ifdef WBUF_COALESCE_EN
      tests++; if (bus.wb_count !== 3'd1) begin fails++; $display("FAIL co_count: got %0d want 1", bus.wb_count); end
      bus.ld_req = 1'b0;
      #1;
      tests++; if (bus.data_sram_wen !== 4'b0011 || bus.data_sram_wdata !== 32'h11112211) begin fails++; $display("FAIL co_merge: got wen %b data %h want 0011 11112211", bus.data_sram_wen, bus.data_sram_wdata); end
      tick();
`else
      tests++; if (bus.wb_count !== 3'd2) begin fails++; $display("FAIL co_count: got %0d want 2", bus.wb_count); end
      bus.ld_req = 1'b0;
      #1;
      tests++; if (bus.data_sram_wen !== 4'b0001 || bus.data_sram_wdata !== 32'h11111111) begin fails++; $display("FAIL co_first: got wen %b data %h want 0001 11111111", bus.data_sram_wen, bus.data_sram_wdata); end
      tick(); #2;
      tests++; if (bus.data_sram_wen !== 4'b0010 || bus.data_sram_wdata !== 32'h22222222) begin fails++; $display("FAIL co_second: got wen %b data %h want 0010 22222222", bus.data_sram_wen, bus.data_sram_wdata); end
      tick();
`endif
      #2;
      tests++; if (bus.wb_empty !== 1'b1) begin fails++; $display("FAIL co_empty: got %b want 1", bus.wb_empty); end
   endtask
   task automatic test_reset_mid();
      idle(); tick();
      bus.ld_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         st(3'b001, 32'h800 + 32'(4 * i), $urandom);
         tick();
      end
      bus.st_valid = 1'b0;
      #2;
      resetn = 1'b0;
      bus.ld_req = 1'b0;
      #1;
      tests++; if (bus.wb_count !== 3'd0 || bus.wb_empty !== 1'b1) begin fails++; $display("FAIL rmid_state: got count %0d empty %b want 0 1", bus.wb_count, bus.wb_empty); end
      tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL rmid_en: got %b want 0", bus.data_sram_en); end
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); #2;
         tests++; if (bus.data_sram_en !== 1'b0) begin fails++; $display("FAIL rmid_write_%0d: got en %b want 0", i, bus.data_sram_en); end
      end
   endtask
   task automatic test_random();
      int kind, r, n;
      logic [3:0] wen;
      logic [31:0] wd;
      logic hz, dr, mg, rdy, mis_e;
      ent_t e;
      idle(); tick();
      q.delete();
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 9);
         bus.st_valid = $urandom_range(0, 99) < 70;
         bus.st_op = (r == 0) ? 3'($urandom) : (r < 4) ? 3'b100 : (r < 7) ? 3'b010 : 3'b001;
         bus.st_addr = 32'h1000 + (32'($urandom_range(0, 5)) << 2) + (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'h0);
         bus.st_data = $urandom;
         bus.ld_req = $urandom_range(0, 99) < 40;
         bus.ld_addr = 32'h1000 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
         fmt(bus.st_op, bus.st_addr, bus.st_data, kind, wen, wd);
         hz = 1'b0;
         foreach (q[i]) if (q[i].w == bus.ld_addr[31:2]) hz = 1'b1;
         if (bus.st_valid && bus.st_addr[31:2] == bus.ld_addr[31:2]) hz = 1'b1;
         hz = hz & bus.ld_req;
         dr = q.size() > 0 && !(bus.ld_req && !hz);
         mg = 1'b0;
`ifdef WBUF_COALESCE_EN
         mg = bus.st_valid && kind == 1 && q.size() > 0 && q[q.size()-1].w == bus.st_addr[31:2] && !(dr && q.size() == 1);
`endif
         rdy = q.size() < DEPTH || mg;
         mis_e = bus.st_valid && kind == 2;
         #2;
         tests++; if (bus.ld_hazard !== hz) begin fails++; $display("FAIL rnd_hazard c%0d: got %b want %b", c, bus.ld_hazard, hz); end
         tests++; if (bus.data_sram_en !== dr) begin fails++; $display("FAIL rnd_en c%0d: got %b want %b", c, bus.data_sram_en, dr); end
         tests++; if (bus.st_ready !== rdy) begin fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.st_ready, rdy); end
         tests++; if (bus.wb_count !== 3'(q.size())) begin fails++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.wb_count, q.size()); end
         if (dr) begin
            tests++; if (bus.data_sram_addr !== {q[0].w, 2'b00} || bus.data_sram_wen !== q[0].wen || bus.data_sram_wdata !== q[0].data) begin
               fails++; $display("FAIL rnd_write c%0d: got %h %b %h want %h %b %h", c, bus.data_sram_addr, bus.data_sram_wen, bus.data_sram_wdata, {q[0].w, 2'b00}, q[0].wen, q[0].data);
            end
         end
         if (mg) begin
            e = q[q.size()-1];
            for (int b = 0; b < 4; b++) if (wen[b]) e.data[8*b +: 8] = wd[8*b +: 8];
            e.wen = e.wen | wen;
            q[q.size()-1] = e;
         end
         if (dr) void'(q.pop_front());
         if (bus.st_valid && kind == 1 && rdy && !mg) q.push_back('{w: bus.st_addr[31:2], wen: wen, data: wd});
         tick();
         tests++; if (bus.st_misalign !== mis_e) begin fails++; $display("FAIL rnd_misalign c%0d: got %b want %b", c, bus.st_misalign, mis_e); end
      end
      idle();
      n = 0;
      while (bus.wb_empty !== 1'b1 && n < 20) begin tick(); n++; end
      tests++; if (bus.wb_empty !== 1'b1) begin fails++; $display("FAIL rnd_flush: got count %0d want 0", bus.wb_count); end
   endtask
   initial begin
      test_reset();
      test_sb();
      test_misalign();
      test_full_drain();
      test_hazard();
      test_full_enq();
      test_coalesce();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
